// File: rtl/program_loader_pkg.sv
// program_loader_pkg: types and constants shared by the program loader.
//   loader_state_t - loader FSM states
//   MAX_LOAD_LEN   - largest accepted program length in bytes
//   COUNT_WIDTH    - width of a counter that must hold 0..MAX_LOAD_LEN
//   is_busy_state  - true for the states that consume stream bytes
package program_loader_pkg;

    localparam int unsigned MAX_LOAD_LEN = 16;
    localparam int unsigned COUNT_WIDTH  = $clog2(MAX_LOAD_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    function automatic logic is_busy_state(input loader_state_t s);
        return (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (length N, N data bytes,
// 8-bit modular checksum) and writes the data bytes into a program RAM
// from address 0, holding the CPU in reset until a load verifies.
//   clk, reset      - clock, synchronous active-high reset
//   start           - request a (re)load; ignored while a load is running
//   in_valid/in_data/in_ready - byte stream handshake
//   ram_we/ram_address/ram_data_in - RAM write port (registered)
//   busy/done/error - load status
//   load_count      - data bytes written in the current load
//   cpu_hold        - low only while a verified program is resident
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   ram_we,
    output logic [ADDR_WIDTH-1:0]  ram_address,
    output logic [DATA_WIDTH-1:0]  ram_data_in,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] load_count,
    output logic                   cpu_hold
);

    loader_state_t          state;
    loader_state_t          state_next;
    logic [COUNT_WIDTH-1:0] length;
    logic [DATA_WIDTH-1:0]  checksum;
    logic                   accept;
    logic                   len_ok;
    logic                   last_data;

    assign accept    = in_valid && in_ready;
    assign len_ok    = (in_data != '0) && (in_data <= DATA_WIDTH'(MAX_LOAD_LEN));
    assign last_data = (load_count + COUNT_WIDTH'(1)) == length;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (start)  state_next = LEN;
            LEN:         if (accept) state_next = len_ok ? DATA : ERROR;
            DATA:        if (accept && last_data) state_next = CSUM;
            CSUM:        if (accept) state_next = (in_data == checksum) ? DONE : ERROR;
            DONE, ERROR: if (start)  state_next = LEN;
            default:     state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they change on the
    // same edge as the state register (cpu_hold rises as DONE is left).
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_hold    <= 1'b1;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            load_count  <= '0;
            length      <= '0;
            checksum    <= '0;
        end else begin
            state    <= state_next;
            in_ready <= is_busy_state(state_next);
            busy     <= is_busy_state(state_next);
            done     <= (state_next == DONE);
            error    <= (state_next == ERROR);
            cpu_hold <= (state_next != DONE);
            ram_we   <= 1'b0;

            if (state == LEN && accept && len_ok) begin
                length     <= COUNT_WIDTH'(in_data);
                load_count <= '0;
                checksum   <= '0;
            end

            if (state == DATA && accept) begin
                ram_we      <= 1'b1;
                ram_address <= ADDR_WIDTH'(load_count);
                ram_data_in <= in_data;
                load_count  <= load_count + COUNT_WIDTH'(1);
                checksum    <= checksum + in_data;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed loads against a stream-history
// model of the loader, with a behavioural program RAM on the write port.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ram_we;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] load_count;
    logic       cpu_hold;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_address(ram_address),
        .ram_data_in(ram_data_in),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .load_count (load_count),
        .cpu_hold   (cpu_hold)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program RAM driven by the loader's write port.
    logic [7:0] ram [16] = '{default: 8'h00};
    int         we_pulses = 0;

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_address] <= ram_data_in;
            we_pulses        <= we_pulses + 1;
        end
    end

    // Model: tracks the bytes of the current frame by position.
    bit         m_active = 1'b0;
    int         m_len    = 0;
    int         m_got    = 0;
    logic [7:0] m_sum    = 8'h00;
    int         m_result = 0;   // 0 none, 1 verified, 2 failed
    int         m_count  = 0;
    bit         m_we     = 1'b0;
    int         m_addr   = 0;
    logic [7:0] m_wdata  = 8'h00;
    logic [7:0] mem [16] = '{default: 8'h00};

    task automatic model_step();
        if (reset) begin
            m_active = 1'b0;
            m_result = 0;
            m_count  = 0;
            m_we     = 1'b0;
            m_addr   = 0;
            m_wdata  = 8'h00;
            return;
        end
        m_we = 1'b0;
        if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_got    = 0;
                m_result = 0;
            end
        end else if (in_valid) begin
            if (m_got == 0) begin
                m_len = int'(in_data);
                if (m_len < 1 || m_len > 16) begin
                    m_active = 1'b0;
                    m_result = 2;
                end else begin
                    m_count = 0;
                    m_sum   = 8'h00;
                end
            end else if (m_got <= m_len) begin
                m_we           = 1'b1;
                m_addr         = m_got - 1;
                m_wdata        = in_data;
                mem[m_got - 1] = in_data;
                m_sum          = m_sum + in_data;
                m_count        = m_count + 1;
            end else begin
                m_result = (in_data == m_sum) ? 1 : 2;
                m_active = 1'b0;
            end
            m_got++;
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (checking) begin
            check("in_ready",    in_ready,    m_active);
            check("busy",        busy,        m_active);
            check("done",        done,        (!m_active && m_result == 1));
            check("error",       error,       (!m_active && m_result == 2));
            check("cpu_hold",    cpu_hold,    !(!m_active && m_result == 1));
            check("ram_we",      ram_we,      m_we);
            check("load_count",  load_count,  m_count);
            check("ram_address", ram_address, m_addr);
            if (m_we) check("ram_data_in", ram_data_in, m_wdata);
        end
    end

    // Stimulus tasks are entered and left just after a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        int t = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 at %0t", $time);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] len, input logic [7:0] d[$],
                            input logic [7:0] csum, input int gapmax, input bit noise);
        pulse_start();
        send_byte(len, $urandom_range(0, gapmax), 1'b0);
        if (len >= 1 && len <= 16) begin
            foreach (d[i]) send_byte(d[i], $urandom_range(0, gapmax), noise);
            send_byte(csum, $urandom_range(0, gapmax), noise);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] s;
        int         p;
        int         n;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        check("rst_cpu_hold",   cpu_hold,   1);
        check("rst_load_count", load_count, 0);
        check("rst_in_ready",   in_ready,   0);
        reset = 1'b0;
        @(negedge clk);

        // N=3 back-to-back
        d = '{8'h11, 8'h22, 8'h33};
        run_load(8'd3, d, 8'h66, 0, 1'b0);
        check("n3_done",     done,       1);
        check("n3_cpu_hold", cpu_hold,   0);
        check("n3_count",    load_count, 3);
        check("n3_ram0",     ram[0],     8'h11);
        check("n3_ram1",     ram[1],     8'h22);
        check("n3_ram2",     ram[2],     8'h33);

        // checksum wrap-around
        d = '{8'hFF, 8'h02};
        run_load(8'd2, d, 8'h01, 1, 1'b0);
        check("wrap_done", done, 1);

        // bad checksum
        d = '{8'hAB};
        run_load(8'd1, d, 8'hAC, 1, 1'b0);
        check("badsum_error",    error,    1);
        check("badsum_cpu_hold", cpu_hold, 1);
        check("badsum_ram0",     ram[0],   8'hAB);

        // illegal lengths
        d = {};
        p = we_pulses;
        run_load(8'h00, d, 8'h00, 0, 1'b0);
        @(negedge clk);
        check("len0_error",  error,     1);
        check("len0_nowr",   we_pulses, p);
        run_load(8'h11, d, 8'h00, 0, 1'b0);
        @(negedge clk);
        check("len17_error", error,     1);
        check("len17_nowr",  we_pulses, p);

        // maximum length with gaps
        d = {};
        for (int i = 0; i < 16; i++) d.push_back(8'(i));
        run_load(8'd16, d, 8'h78, 3, 1'b0);
        check("n16_done",  done,       1);
        check("n16_count", load_count, 16);
        check("n16_ram15", ram[15],    8'h0F);

        // reset after 2 of 4 data bytes, together with start and in_valid
        p = we_pulses;
        pulse_start();
        send_byte(8'd4, 0, 1'b0);
        send_byte(8'hA1, 0, 1'b0);
        send_byte(8'hA2, 0, 1'b0);
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA3;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("mid_busy",     busy,        0);
        check("mid_count",    load_count,  0);
        check("mid_address",  ram_address, 0);
        check("mid_cpu_hold", cpu_hold,    1);
        check("mid_ready",    in_ready,    0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("mid_writes", we_pulses - p, 2);

        // randomized loads
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(0, 18);
            d = {};
            s = 8'h00;
            for (int i = 0; i < n; i++) begin
                d.push_back(8'($urandom));
                s = s + d[i];
            end
            if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
            run_load(8'(n), d, s, 2, 1'b1);
            @(negedge clk);
        end

        for (int i = 0; i < 16; i++) check("ram_readback", ram[i], mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning byte width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port in_valid  input  1  stream byte present.
REQ-007 SHALL have port in_data  input  8  stream byte.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-009 SHALL have port ram_we  output  1  RAM write enable, drives ram.we.
REQ-010 SHALL have port ram_address  output  4  RAM address, drives ram.address.
REQ-011 SHALL have port ram_data_in  output  8  RAM write data, drives ram.data_in.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  load finished, checksum matched.
REQ-014 SHALL have port error  output  1  load aborted: bad length or checksum mismatch.
REQ-015 SHALL have port load_count  output  5  data bytes written this load, 0..16.
REQ-016 SHALL have port cpu_hold  output  1  holds CPU in reset while loader does not own a valid program.

Function
REQ-017 SHALL frame the stream as: length byte N, then N data bytes, then one checksum byte.
REQ-018 SHALL implement states IDLE, LEN, DATA, CSUM, DONE, ERROR.
REQ-019 SHALL assert in_ready only in LEN, DATA, CSUM; a byte is accepted on a rising edge where in_valid && in_ready.
REQ-020 SHALL move IDLE->LEN on start; start SHALL be ignored in LEN, DATA, CSUM.
REQ-021 SHALL on accepted length: N in 1..16 -> DATA, clear load_count and checksum; N==0 or N>16 -> ERROR.
REQ-022 SHALL, for each accepted data byte k (0-based), register ram_we=1, ram_address=k, ram_data_in=byte in the cycle after acceptance, for exactly one cycle.
REQ-023 SHALL support back-to-back acceptance (one byte per cycle) with one write pulse per byte; ram_we low whenever no byte was accepted the previous cycle.
REQ-024 SHALL accumulate checksum as 8-bit sum of data bytes modulo 256; length byte excluded.
REQ-025 SHALL increment load_count per written byte; after byte N-1 -> CSUM.
REQ-026 SHALL on accepted checksum byte: equal -> DONE, unequal -> ERROR.
REQ-027 SHALL hold DONE/ERROR until start, then go to LEN (reload overwrites RAM from address 0).
REQ-028 SHALL drive busy=1 in LEN, DATA, CSUM; done=1 only in DONE; error=1 only in ERROR.
REQ-029 SHALL drive cpu_hold=0 only in DONE; on restart cpu_hold SHALL rise in the same cycle state leaves DONE.
REQ-030 SHALL never write addresses >= N in a load; ram_address SHALL hold last value when ram_we=0.

Reset
REQ-031 SHALL on reset, including mid-load, enter IDLE next edge: ram_we=0, ram_address=0, ram_data_in=0, in_ready=0, busy=0, done=0, error=0, load_count=0, cpu_hold=1, checksum=0.
REQ-032 SHALL give reset priority over start and in_valid in the same cycle.

Structure
REQ-033 SHALL place the state enum (loader_state_t) and MAX_LOAD_LEN=16 in the shared package.
REQ-034 SHALL be a single module, no sub-modules; RAM instantiated only in the bench/top.

Verification
REQ-035 Load N=3 {0x11,0x22,0x33}, csum 0x66, back-to-back -> RAM[0..2]=11,22,33, load_count=3, done=1, cpu_hold=0; readback via oe matches.
REQ-036 Load N=2 {0xFF,0x02}, csum 0x01 -> wrap-around sum matches, done=1.
REQ-037 Load N=1 {0xAB}, csum 0xAC -> error=1, cpu_hold=1, RAM[0]=AB.
REQ-038 Length 0x00 and 0x11 -> error=1, no ram_we pulse.
REQ-039 N=16 with in_valid gaps, bytes 0x00..0x0F, csum 0x78 -> RAM[15]=0F, load_count=16, done=1.
REQ-040 Reset asserted after 2 of 4 data bytes -> IDLE next edge, all outputs at reset values, no further writes.
